// File: rtl/dmem_sraml_bridge_pkg.sv
// Shared definitions for the memory-side bus bridges: size codes, FSM state
// encoding and the kseg0/kseg1 physical mapping constants.
// Latency: n/a (definitions only). Backpressure: n/a.
package mips_defs;

  // Bus transfer size codes carried on data_size.
  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // Bridge FSM state encoding.
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_DATA = 2'd1,
    ST_DONE      = 2'd2
  } state_t;

  // Virtual bits [31:30] == 2'b10 select kseg0/kseg1 (0x8000_0000-0xBFFF_FFFF).
  // Both map onto physical 0x0000_0000-0x1FFF_FFFF by clearing bits [31:29].
  localparam logic [1:0]  KSEG01_TAG     = 2'b10;
  localparam logic [31:0] KSEG_PHYS_MASK = 32'h1FFF_FFFF;

  // Byte strobes -> bus size. Reads and full-word writes are word accesses;
  // unsupported strobe patterns also fall back to word.
  function automatic logic [1:0] wen_to_size(input logic [3:0] wen);
    logic [1:0] size;
    case (wen)
      4'b0011, 4'b1100:                   size = SIZE_HALF;
      4'b0001, 4'b0010, 4'b0100, 4'b1000: size = SIZE_BYTE;
      default:                            size = SIZE_WORD;
    endcase
    return size;
  endfunction

  // True for the strobe patterns the bus can express directly.
  function automatic logic wen_legal(input logic [3:0] wen);
    logic ok;
    case (wen)
      4'b0000, 4'b1111, 4'b0011, 4'b1100,
      4'b0001, 4'b0010, 4'b0100, 4'b1000: ok = 1'b1;
      default:                            ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dmem_addr_map.sv
// Virtual-to-physical address map (fixed kseg0/kseg1 fold) plus read word alignment.
// Latency: purely combinational. Backpressure: none (no state, no handshake).
// Ports: vaddr (virtual byte address), word_align (1 = clear bits [1:0]), paddr (physical address).
module dmem_addr_map
  import mips_defs::*;
#(
  parameter bit MAP_KSEG = 1'b1
) (
  input  logic [31:0] vaddr,
  input  logic        word_align,
  output logic [31:0] paddr
);

  always_comb begin
    paddr = vaddr;
    if (MAP_KSEG && (vaddr[31:30] == KSEG01_TAG)) begin
      paddr = vaddr & KSEG_PHYS_MASK;
    end
    // Reads always fetch the whole word; lane selection happens downstream.
    if (word_align) begin
      paddr[1:0] = 2'b00;
    end
  end

endmodule

// File: rtl/dmem_sraml_bridge.sv
// Bridges the memory stage's single-cycle SRAM port onto a split-transaction req/addr_ok/data_ok bus.
// Latency: completes in the cycle data_data_ok arrives (0 extra cycles when addr_ok and data_ok coincide).
// Backpressure: d_stall holds the pipeline until completion; read data is held while longest_stall is high.
// Ports: clk/rst (async active-low); mem_* datapath side; longest_stall global stall in; d_stall out;
//        data_* bus side (req/wr/size/addr/wdata out, addr_ok/data_ok/rdata in).
module dmem_sraml_bridge
  import mips_defs::*;
#(
  parameter bit MAP_KSEG = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_en,
  input  logic [3:0]  mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  input  logic        longest_stall,
  output logic        d_stall,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata
);

  state_t      state;
  state_t      state_nxt;
  logic [31:0] saved_rdata;
  logic        is_read;
  logic        completion;

  assign is_read = (mem_wen == 4'b0000);

  // Request fields follow the memory-stage inputs directly; the pipeline is
  // frozen by d_stall, so they stay stable while data_req is high.
  assign data_wr    = ~is_read;
  assign data_wdata = mem_wdata;
  assign data_size  = wen_to_size(mem_wen);

  dmem_addr_map #(
    .MAP_KSEG (MAP_KSEG)
  ) u_addr_map (
    .vaddr      (mem_addr),
    .word_align (is_read),
    .paddr      (data_addr)
  );

  // Completion is either a zero-wait accept+response in IDLE or the response
  // arriving in WAIT_DATA. A data_ok seen in DONE is a protocol error and is ignored.
  // All combinational outputs are gated by rst so they read 0 during reset.
  assign completion = rst & (((state == ST_IDLE) & mem_en & data_addr_ok & data_data_ok) |
                             ((state == ST_WAIT_DATA) & data_data_ok));

  assign data_req  = rst & mem_en & (state == ST_IDLE);
  assign d_stall   = rst & mem_en & (state != ST_DONE) & ~completion;
  assign mem_rdata = completion ? data_rdata : saved_rdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      saved_rdata <= 32'h0;
    end else begin
      state <= state_nxt;
      // Write completions carry no data; keep the last read value.
      if (completion && is_read) begin
        saved_rdata <= data_rdata;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (mem_en && data_addr_ok) begin
          if (data_data_ok) begin
            state_nxt = longest_stall ? ST_DONE : ST_IDLE;
          end else begin
            state_nxt = ST_WAIT_DATA;
          end
        end
      end
      ST_WAIT_DATA: begin
        if (data_data_ok) begin
          state_nxt = longest_stall ? ST_DONE : ST_IDLE;
        end
      end
      ST_DONE: begin
        // A new access seen on this exit cycle is only requested from IDLE
        // on the following cycle, which guarantees one idle bus cycle.
        if (!longest_stall) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Strobe patterns other than byte/half/word cannot be expressed on the bus.
  always_comb begin
    if (data_req) begin
      assert (wen_legal(mem_wen))
        else $error("dmem_sraml_bridge: unsupported write strobe pattern %b", mem_wen);
    end
  end

endmodule

// File: tb/tb_dmem_sraml_bridge.sv
// Directed self-checking bench for dmem_sraml_bridge (mapped and unmapped instances).
module tb_dmem_sraml_bridge;
  import mips_defs::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_en;
  logic [3:0]  mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        longest_stall;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  logic [31:0] mem_rdata,  mem_rdata0;
  logic        d_stall,    d_stall0;
  logic        data_req,   data_req0;
  logic        data_wr,    data_wr0;
  logic [1:0]  data_size,  data_size0;
  logic [31:0] data_addr,  data_addr0;
  logic [31:0] data_wdata, data_wdata0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_sraml_bridge #(.MAP_KSEG(1'b1)) dut (
    .clk(clk), .rst(rst), .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .longest_stall(longest_stall),
    .d_stall(d_stall), .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata)
  );

  dmem_sraml_bridge #(.MAP_KSEG(1'b0)) dut0 (
    .clk(clk), .rst(rst), .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata0), .longest_stall(longest_stall),
    .d_stall(d_stall0), .data_req(data_req0), .data_wr(data_wr0), .data_size(data_size0),
    .data_addr(data_addr0), .data_wdata(data_wdata0), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with an access already presented: outputs must stay 0.
    rst = 1'b0; mem_en = 1'b1; mem_wen = 4'b0000; mem_addr = 32'hBFC0_0010;
    mem_wdata = 32'h0; longest_stall = 1'b0; data_addr_ok = 1'b0;
    data_data_ok = 1'b1; data_rdata = 32'hFFFF_FFFF;
    #1;
    chk("rst_req",   32'(data_req), 32'd0);
    chk("rst_stall", 32'(d_stall), 32'd0);
    chk("rst_rdata", mem_rdata, 32'h0);
    chk("rst_state", 32'(dut.state), 32'(ST_IDLE));
    step();
    mem_en = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;
    rst = 1'b1;
    step();

    // Word read from kseg1, addr_ok in cycle 1, data_ok in cycle 3.
    mem_en = 1'b1; mem_wen = 4'b0000; mem_addr = 32'hBFC0_0010; data_addr_ok = 1'b1;
    #1;
    chk("rd_c1_req",  32'(data_req), 32'd1);
    chk("rd_c1_addr", data_addr, 32'h1FC0_0010);
    chk("rd_c1_addr_nomap", data_addr0, 32'hBFC0_0010);
    chk("rd_c1_size", 32'(data_size), 32'(SIZE_WORD));
    chk("rd_c1_wr",   32'(data_wr), 32'd0);
    chk("rd_c1_stall", 32'(d_stall), 32'd1);
    step();
    data_addr_ok = 1'b0;
    #1;
    chk("rd_c2_state", 32'(dut.state), 32'(ST_WAIT_DATA));
    chk("rd_c2_req",   32'(data_req), 32'd0);
    chk("rd_c2_stall", 32'(d_stall), 32'd1);
    step();
    data_data_ok = 1'b1; data_rdata = 32'hDEAD_BEEF;
    #1;
    chk("rd_c3_stall", 32'(d_stall), 32'd0);
    chk("rd_c3_rdata", mem_rdata, 32'hDEAD_BEEF);
    step();
    mem_en = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;
    #1;
    chk("rd_after_state", 32'(dut.state), 32'(ST_IDLE));
    chk("rd_after_hold",  mem_rdata, 32'hDEAD_BEEF);
    step();

    // Byte store into kseg0.
    mem_en = 1'b1; mem_wen = 4'b1000; mem_addr = 32'h8000_0003; mem_wdata = 32'hAB00_0000;
    data_addr_ok = 1'b1;
    #1;
    chk("sb_addr",  data_addr, 32'h0000_0003);
    chk("sb_addr_nomap", data_addr0, 32'h8000_0003);
    chk("sb_size",  32'(data_size), 32'(SIZE_BYTE));
    chk("sb_wr",    32'(data_wr), 32'd1);
    chk("sb_wdata", data_wdata, 32'hAB00_0000);
    chk("sb_req",   32'(data_req), 32'd1);
    step();
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h5555_5555;
    #1;
    chk("sb_done_stall", 32'(d_stall), 32'd0);
    step();
    mem_en = 1'b0; mem_wen = 4'b0000; data_data_ok = 1'b0; data_rdata = 32'h0;
    #1;
    chk("sb_saved_kept", dut.saved_rdata, 32'hDEAD_BEEF);
    chk("sb_state", 32'(dut.state), 32'(ST_IDLE));
    step();

    // Read (unaligned address forced to word) completing under a global stall.
    mem_en = 1'b1; mem_addr = 32'h0000_0106; data_addr_ok = 1'b1; longest_stall = 1'b1;
    #1;
    chk("hold_addr", data_addr, 32'h0000_0104);
    step();
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h1234_5678;
    #1;
    chk("hold_cpl_stall", 32'(d_stall), 32'd0);
    chk("hold_cpl_rdata", mem_rdata, 32'h1234_5678);
    step();
    data_data_ok = 1'b0; data_rdata = 32'h0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("hold_state_%0d", i), 32'(dut.state), 32'(ST_DONE));
      chk($sformatf("hold_stall_%0d", i), 32'(d_stall), 32'd0);
      chk($sformatf("hold_rdata_%0d", i), mem_rdata, 32'h1234_5678);
      chk($sformatf("hold_req_%0d", i),   32'(data_req), 32'd0);
      step();
    end
    // Stall releases; next access presented on the same cycle waits one cycle.
    longest_stall = 1'b0; mem_addr = 32'h0000_2000;
    #1;
    chk("exit_req", 32'(data_req), 32'd0);
    chk("exit_rdata", mem_rdata, 32'h1234_5678);
    step();

    // Zero-wait accept and response in the request cycle.
    data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = 32'hCAFE_F00D;
    #1;
    chk("zw_state", 32'(dut.state), 32'(ST_IDLE));
    chk("zw_req",   32'(data_req), 32'd1);
    chk("zw_stall", 32'(d_stall), 32'd0);
    chk("zw_rdata", mem_rdata, 32'hCAFE_F00D);
    step();
    mem_en = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;
    #1;
    chk("zw_saved", mem_rdata, 32'hCAFE_F00D);
    step();

    // Halfword store, unmapped low address; kseg2 read left unmapped.
    mem_en = 1'b1; mem_wen = 4'b1100; mem_addr = 32'h0000_1002; mem_wdata = 32'h5A5A_0000;
    #1;
    chk("sh_addr_nomap", data_addr0, 32'h0000_1002);
    chk("sh_addr_map",   data_addr, 32'h0000_1002);
    chk("sh_size",       32'(data_size0), 32'(SIZE_HALF));
    mem_wen = 4'b0011;
    #1;
    chk("sh_lo_size", 32'(data_size), 32'(SIZE_HALF));
    mem_wen = 4'b1111; mem_addr = 32'hA000_0001;
    #1;
    chk("sw_size", 32'(data_size), 32'(SIZE_WORD));
    chk("sw_addr", data_addr, 32'h0000_0001);
    mem_wen = 4'b0000; mem_addr = 32'hC000_000A;
    #1;
    chk("kseg2_addr", data_addr, 32'hC000_0008);
    step();
    mem_en = 1'b0;
    step();

    // Reset while waiting for data: abandoned, then a fresh request.
    mem_en = 1'b1; mem_wen = 4'b0000; mem_addr = 32'h0000_0040; data_addr_ok = 1'b1;
    step();
    data_addr_ok = 1'b0;
    #1;
    chk("ar_wait_state", 32'(dut.state), 32'(ST_WAIT_DATA));
    rst = 1'b0;
    #1;
    chk("ar_req",   32'(data_req), 32'd0);
    chk("ar_stall", 32'(d_stall), 32'd0);
    chk("ar_rdata", mem_rdata, 32'h0);
    chk("ar_state", 32'(dut.state), 32'(ST_IDLE));
    rst = 1'b1;
    #1;
    chk("ar_fresh_req", 32'(data_req), 32'd1);
    chk("ar_fresh_addr", data_addr, 32'h0000_0040);
    data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = 32'h0000_0077;
    #1;
    chk("ar_fresh_rdata", mem_rdata, 32'h0000_0077);
    step();
    mem_en = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;
    #1;
    chk("ar_end_state", 32'(dut.state), 32'(ST_IDLE));
    chk("ar_end_saved", mem_rdata, 32'h0000_0077);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
